instr_prefetch: RTL and testbench
=================================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, giving the number of prefetch queue entries (power of two, 2..8).
REQ-002 The block SHALL have a port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have a port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have a port rom_addr  output  16  word address presented to the instruction ROM (ROM returns data one cycle after the edge that samples it).
REQ-005 The block SHALL have a port rom_data  input  16  instruction word returned by the ROM.
REQ-006 The block SHALL have a port flush  input  1  discard all queued and in-flight words and redirect fetch.
REQ-007 The block SHALL have a port flush_addr  input  16  new fetch address, sampled when flush=1.
REQ-008 The block SHALL have a port instr_out  output  16  instruction at queue head.
REQ-009 The block SHALL have a port instr_pc  output  16  address of instr_out.
REQ-010 The block SHALL have a port instr_valid  output  1  queue head holds a valid word.
REQ-011 The block SHALL have a port instr_ready  input  1  consumer (control unit) accepts head this cycle.
REQ-012 The block SHALL have a port level  output  4  number of valid queue entries (0..DEPTH).

Function
REQ-013 The block SHALL drive rom_addr combinationally from internal register fetch_pc.
REQ-014 The block SHALL issue a read in a cycle when flush=0 and (level + inflight) < DEPTH, counting any same-cycle pop as freed space; fetch_pc then increments by 1 and inflight is set; otherwise inflight clears.
REQ-015 The block SHALL push {fetch_pc of issue, rom_data} into the queue on the cycle after an issue (inflight=1) unless flush=1 that cycle.
REQ-016 The block SHALL pop the head when instr_valid=1 and instr_ready=1 and flush=0; instr_ready while instr_valid=0 has no effect.
REQ-017 The block SHALL hold instr_valid = (level != 0), with instr_out/instr_pc from the head entry, stable until popped.
REQ-018 The block SHALL support push and pop in the same cycle, leaving level unchanged.
REQ-019 The block SHALL never overflow: when level + inflight = DEPTH no read is issued; rom_addr still shows fetch_pc.
REQ-020 On flush=1 the block SHALL empty the queue (level=0 next cycle), drop any in-flight word, ignore same-cycle pop and push, issue no read, and load fetch_pc <= flush_addr.
REQ-021 The block SHALL issue a read of flush_addr in the cycle after the flush and assert instr_valid with instr_pc=flush_addr two cycles after the flush cycle.
REQ-022 The block SHALL wrap fetch_pc from 16'hFFFF to 16'h0000 without stall.
REQ-023 The block SHALL have read-to-valid latency of 2 cycles (issue edge, capture edge, visible after).
REQ-024 The block SHALL accept flush on consecutive cycles, the last flush_addr winning.

Reset
REQ-025 While rst=1 the block SHALL force fetch_pc=0 (rom_addr=0), level=0, inflight=0, instr_valid=0, instr_out=0, instr_pc=0, queue pointers=0.
REQ-026 The block SHALL issue its first read (address 0) in the first cycle after rst deasserts; rst asserted mid-operation discards all queued/in-flight words immediately.

Configuration
REQ-027 With macro PREFETCH_STALL_CNT_EN defined the block SHALL add output stall_cnt (16 bits): increments each cycle instr_ready=1 and instr_valid=0, saturates at 16'hFFFF, cleared by rst only.
REQ-028 Without PREFETCH_STALL_CNT_EN the block SHALL have no stall_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-029 The bench SHALL cover: ROM[0..3]=9101,9202,9303,9404, rst released, instr_ready=1 -> instr_valid first high 2 cycles after release, then pc 0,1,2,3 with those words on consecutive cycles.
REQ-030 The bench SHALL cover: instr_ready=0 for 10 cycles -> level reaches 4 (DEPTH=4), rom_addr stuck at 4, no further issue; ready=1 -> words 0..3 then 4 without gap or loss.
REQ-031 The bench SHALL cover: flush=1, flush_addr=0x0020 with level=3 and read in flight -> level=0 next cycle, next valid word has instr_pc=0x0020 exactly 2 cycles after flush, stale words never presented.
REQ-032 The bench SHALL cover: flush to 0xFFFE, ready=1 -> instr_pc sequence FFFE, FFFF, 0000, 0001.
REQ-033 The bench SHALL cover: rst pulsed asynchronously mid-cycle with level=2 -> instr_valid=0 and rom_addr=0 immediately, fetch restarts at 0 after release.
REQ-034 The bench SHALL cover (PREFETCH_STALL_CNT_EN): ready=1 held from reset release -> stall_cnt=2 when first word becomes valid; after a flush with ready=1 -> stall_cnt increases by 2.

Source files
------------

// File: rtl/instr_prefetch_if.sv
// ============================================================================
//  Module   : instr_prefetch_if
//  Brief    : ROM fetch, flush redirect and consumer handshake bundle for
//             instr_prefetch.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_prefetch_if;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        flush;
    logic [15:0] flush_addr;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  level;

    // master = the prefetcher, slave = ROM plus consumer side
    modport master (
        output rom_addr,
        input  rom_data,
        input  flush,
        input  flush_addr,
        output instr_out,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        output level
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output flush,
        output flush_addr,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        input  level
    );
endinterface

`default_nettype wire

// File: rtl/instr_prefetch.sv
// ============================================================================
//  Module   : instr_prefetch
//  Brief    : Instruction prefetch queue in front of a 1-cycle-latency ROM,
//             with flush/redirect. Optional macro PREFETCH_STALL_CNT_EN adds
//             a saturating consumer stall counter output (stall_cnt).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_prefetch #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_prefetch_if.master      bus
`ifdef PREFETCH_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int        PW      = $clog2(DEPTH);
    localparam logic [4:0] c_DEPTH = 5'(DEPTH);

    logic [15:0]   r_fetch_pc;
    logic [15:0]   r_inflight_pc;
    logic          r_inflight;
    logic [15:0]   r_q_data [DEPTH];
    logic [15:0]   r_q_pc   [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [3:0]    r_level;

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [4:0]    w_occupancy;

    assign w_pop       = (r_level != 4'd0) && bus.instr_ready && !bus.flush;
    assign w_push      = r_inflight && !bus.flush;
    // Slots already spoken for (queued + in flight), minus the one freed by a pop now
    assign w_occupancy = {1'b0, r_level} + {4'd0, r_inflight} - {4'd0, w_pop};
    assign w_issue     = !bus.flush && (w_occupancy < c_DEPTH);

    assign bus.rom_addr    = r_fetch_pc;
    assign bus.instr_valid = (r_level != 4'd0);
    assign bus.instr_out   = r_q_data[r_rptr];
    assign bus.instr_pc    = r_q_pc[r_rptr];
    assign bus.level       = r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= '0;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
        end else if (bus.flush) begin
            r_fetch_pc    <= bus.flush_addr;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight    <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_q_data[r_wptr] <= bus.rom_data;
                r_q_pc[r_wptr]   <= r_inflight_pc;
                r_wptr           <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 4'd1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 4'd1;
            end
        end
    end

`ifdef PREFETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (bus.instr_ready && (r_level == 4'd0) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch.sv
// ============================================================================
//  Module   : tb_instr_prefetch
//  Brief    : Self-checking bench for instr_prefetch (per-cycle vector table,
//             hand-written reset sequence, scoreboarded random-ready stream).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [15:0] faddr;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic [3:0]  exp_level;
        logic [15:0] exp_rom_addr;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        sb_en;
    int          n_chk;
    int          n_fail;
    int          n_pop;
    vec_t        vecs[$];
    sb_t         sb[$];

    instr_prefetch_if bus();

`ifdef PREFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_mark;
`endif

    instr_prefetch #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef PREFETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h9101;
            16'h0001: return 16'h9202;
            16'h0002: return 16'h9303;
            16'h0003: return 16'h9404;
            default:  return a ^ 16'h5A00;
        endcase
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic [15:0] fa,
                                input logic rdy, input logic ev, input logic [15:0] epc,
                                input logic [3:0] elv, input logic [15:0] era);
        vec_t v;
        v.rst = r; v.flush = f; v.faddr = fa; v.ready = rdy;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_level = elv; v.exp_rom_addr = era;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_load(input logic [15:0] start);
        sb.delete();
        for (int k = 0; k < 300; k++) begin
            sb_t e;
            e.pc   = start + 16'(k);
            e.data = rom_fn(e.pc);
            sb.push_back(e);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: registered read, data valid one cycle after the sampling edge
    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (bus.level > 4'd4) begin
                chk("level_bound", 32'(bus.level), 32'd4);
            end
            if (bus.instr_valid && bus.instr_ready && !bus.flush) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(bus.instr_pc), 32'hFFFF_FFFF);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_pc",   32'(bus.instr_pc),  32'(e.pc));
                    chk("sb_data", 32'(bus.instr_out), 32'(e.data));
                    n_pop++;
                end
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; n_pop = 0; sb_en = 1'b0;
        rst = 1'b1;
        bus.flush = 1'b0; bus.flush_addr = '0; bus.instr_ready = 1'b1;

        // rst, flush, faddr, ready | valid, pc, level, rom_addr (after the edge)
        vecs.push_back(mk(0,0,16'h0000,1, 0,16'h0000,0,16'h0001));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0000,1,16'h0002));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0001,1,16'h0003));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0002,1,16'h0004));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0003,1,16'h0005));
        vecs.push_back(mk(1,0,16'h0000,0, 0,16'h0000,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,0, 0,16'h0000,0,16'h0001));
        vecs.push_back(mk(0,0,16'h0000,0, 1,16'h0000,1,16'h0002));
        vecs.push_back(mk(0,0,16'h0000,0, 1,16'h0000,2,16'h0003));
        vecs.push_back(mk(0,0,16'h0000,0, 1,16'h0000,3,16'h0004));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0,0,16'h0000,0, 1,16'h0000,4,16'h0004));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0001,3,16'h0005));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0002,3,16'h0006));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0003,3,16'h0007));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0004,3,16'h0008));
        vecs.push_back(mk(0,1,16'h0020,1, 0,16'h0000,0,16'h0020));
        vecs.push_back(mk(0,0,16'h0000,1, 0,16'h0000,0,16'h0021));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0020,1,16'h0022));
        vecs.push_back(mk(0,1,16'hFFFE,1, 0,16'h0000,0,16'hFFFE));
        vecs.push_back(mk(0,0,16'h0000,1, 0,16'h0000,0,16'hFFFF));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'hFFFE,1,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'hFFFF,1,16'h0001));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0000,1,16'h0002));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h0001,1,16'h0003));
        vecs.push_back(mk(0,1,16'h1000,1, 0,16'h0000,0,16'h1000));
        vecs.push_back(mk(0,1,16'h2000,1, 0,16'h0000,0,16'h2000));
        vecs.push_back(mk(0,0,16'h0000,1, 0,16'h0000,0,16'h2001));
        vecs.push_back(mk(0,0,16'h0000,1, 1,16'h2000,1,16'h2002));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_level", 32'(bus.level),       32'd0);
        chk("rst_rom",   32'(bus.rom_addr),    32'd0);
        chk("rst_pc",    32'(bus.instr_pc),    32'd0);
        chk("rst_instr", 32'(bus.instr_out),   32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            rst = v.rst; bus.flush = v.flush; bus.flush_addr = v.faddr; bus.instr_ready = v.ready;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), 32'(bus.instr_valid), 32'(v.exp_valid));
            chk($sformatf("row%0d_level", i), 32'(bus.level),       32'(v.exp_level));
            chk($sformatf("row%0d_rom",   i), 32'(bus.rom_addr),    32'(v.exp_rom_addr));
            if (v.exp_valid || v.rst) begin
                chk($sformatf("row%0d_pc",    i), 32'(bus.instr_pc),  32'(v.exp_pc));
                chk($sformatf("row%0d_instr", i), 32'(bus.instr_out),
                    v.rst ? 32'd0 : 32'(rom_fn(v.exp_pc)));
            end
`ifdef PREFETCH_STALL_CNT_EN
            if (i == 1) chk("stall_first_valid", 32'(stall_cnt), 32'd2);
            if (i == 20) stall_mark = stall_cnt;
            if (i == 22) chk("stall_after_flush", 32'(stall_cnt), 32'(stall_mark + 16'd2));
`endif
        end
        bus.flush = 1'b0;

        // Asynchronous reset mid-cycle with two words queued
        bus.instr_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_pre_level", 32'(bus.level), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_rom",   32'(bus.rom_addr),    32'd0);
        chk("arst_level", 32'(bus.level),       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_rel_rom",   32'(bus.rom_addr),    32'd1);
        chk("arst_rel_valid", 32'(bus.instr_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_rel_pc",    32'(bus.instr_pc),  32'd0);
        chk("arst_rel_instr", 32'(bus.instr_out), 32'h9101);

        // Random consumer backpressure with mid-stream redirects
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb_load(16'h0000);
        sb_en = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            bus.instr_ready = 1'($urandom_range(0, 1));
            if (c == 60 || c == 130) begin
                bus.flush      = 1'b1;
                bus.flush_addr = 16'($urandom_range(16'hFF00, 16'hFFFF));
                sb_load(bus.flush_addr);
            end else begin
                bus.flush = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        sb_en = 1'b0;
        bus.flush = 1'b0;
        chk("sb_progress", 32'(n_pop > 40), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
